window_3x3_gen: RTL and testbench

Builds a 3×3 neighbourhood window from a raster pixel stream, for the census transform stage of the SGM pipeline. Two `ram_delay_line` instances of length `IMG_WIDTH` provide the previous two image rows. Three column shift registers assemble the window. Row and column counters decide when all nine taps hold in-image pixels. All stages share the global `ce` pipeline enable.

---
 rtl/window_3x3_gen_pkg.sv | 28 ++
 rtl/ram_delay_line.sv | 35 +++
 rtl/window_3x3_gen.sv | 117 +++++++++++
 tb/tb_window_3x3_gen.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/window_3x3_gen_pkg.sv
// Shared constants for the 3x3 window generator and the downstream census stage:
// tap indices (k = 3*row + col, row 0 = top, col 0 = left) and a clog2 helper.
package window_3x3_gen_pkg;

  localparam int WIN_ROWS = 3;
  localparam int WIN_COLS = 3;

  localparam int TAP_TL = 0;
  localparam int TAP_TC = 1;
  localparam int TAP_TR = 2;
  localparam int TAP_ML = 3;
  localparam int TAP_MC = 4;
  localparam int TAP_MR = 5;
  localparam int TAP_BL = 6;
  localparam int TAP_BC = 7;
  localparam int TAP_BR = 8;

  // Number of bits needed to index v entries (v >= 2).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ram_delay_line.sv
// Fixed-length delay line on a circular RAM. Each accepted (ce=1) sample is
// written at the pointer while the sample written DELAY accepts earlier is read
// out there, so dout is the input delayed by DELAY accepted samples.
// Contents are never cleared; rst only realigns the pointer.
module ram_delay_line #(
  parameter int WIDTH = 8,
  parameter int DELAY = 640
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam logic [AW-1:0] PTR_LAST = AW'(DELAY - 1);

  logic [WIDTH-1:0] mem_q [DELAY];
  logic [AW-1:0]    ptr_q;

  assign dout = mem_q[ptr_q];

  // Write the accepted sample over the one just read out.
  always_ff @(posedge clk) begin
    if (ce) mem_q[ptr_q] <= din;
  end

  // Circular pointer with explicit wrap at DELAY-1.
  always_ff @(posedge clk) begin
    if (rst)     ptr_q <= '0;
    else if (ce) ptr_q <= (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
  end

endmodule

// File: rtl/window_3x3_gen.sv
// 3x3 neighbourhood window from a raster pixel stream. Two line buffers supply
// the previous two rows, two history columns per row plus the live row taps
// form the window, and position counters decide when all nine taps are
// in-image. window_out and the centre coordinates only load on valid edges.
module window_3x3_gen
  import window_3x3_gen_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int IMG_WIDTH  = 640,
  parameter  int IMG_HEIGHT = 480,
  localparam int CW         = clog2(IMG_WIDTH),
  localparam int RW         = clog2(IMG_HEIGHT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ce,
  input  logic                    sof,
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic [9*DATA_WIDTH-1:0] window_out,
  output logic                    win_valid,
  output logic [CW-1:0]           center_col,
  output logic [RW-1:0]           center_row
);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0] col_q, col_d, col_eff;
  logic [RW-1:0] row_q, row_d, row_eff;
  logic          valid_d;
  logic          win_valid_q;
  logic [CW-1:0] center_col_q;
  logic [RW-1:0] center_row_q;

  logic [DATA_WIDTH-1:0]   r1, r2;
  logic [DATA_WIDTH-1:0]   tap    [WIN_ROWS];
  logic [DATA_WIDTH-1:0]   hist_q [WIN_ROWS][2];
  logic [9*DATA_WIDTH-1:0] win_next, window_q;

  // Line buffers: r1 is the row above the input, r2 the row above that.
  ram_delay_line #(.WIDTH(DATA_WIDTH), .DELAY(IMG_WIDTH)) u_line1 (
    .clk (clk), .rst (1'b0), .ce (ce), .din (data_in), .dout (r1)
  );
  ram_delay_line #(.WIDTH(DATA_WIDTH), .DELAY(IMG_WIDTH)) u_line2 (
    .clk (clk), .rst (1'b0), .ce (ce), .din (r1), .dout (r2)
  );

  // Effective position of the pixel being accepted (sof forces 0,0).
  assign col_eff = sof ? '0 : col_q;
  assign row_eff = sof ? '0 : row_q;
  assign valid_d = ce && (row_eff >= RW'(2)) && (col_eff >= CW'(2));

  // Next counter values: step from the effective position with explicit wraps.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (ce) begin
      if (col_eff == COL_LAST) begin
        col_d = '0;
        row_d = (row_eff == ROW_LAST) ? '0 : row_eff + 1'b1;
      end else begin
        col_d = col_eff + 1'b1;
        row_d = row_eff;
      end
    end
  end

  // Window as it stands on this edge: two history columns plus the live taps.
  always_comb begin
    tap[0]   = r2;
    tap[1]   = r1;
    tap[2]   = data_in;
    win_next = '0;
    for (int i = 0; i < WIN_ROWS; i++) begin
      win_next[(3*i+0)*DATA_WIDTH +: DATA_WIDTH] = hist_q[i][0];
      win_next[(3*i+1)*DATA_WIDTH +: DATA_WIDTH] = hist_q[i][1];
      win_next[(3*i+2)*DATA_WIDTH +: DATA_WIDTH] = tap[i];
    end
  end

  // Counters, column history, captured window and centre coordinates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      center_col_q <= '0;
      center_row_q <= '0;
      window_q     <= '0;
      for (int i = 0; i < WIN_ROWS; i++) begin
        hist_q[i][0] <= '0;
        hist_q[i][1] <= '0;
      end
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= valid_d;
      if (ce) begin
        for (int i = 0; i < WIN_ROWS; i++) begin
          hist_q[i][0] <= hist_q[i][1];
          hist_q[i][1] <= tap[i];
        end
      end
      if (valid_d) begin
        window_q     <= win_next;
        center_col_q <= col_eff - 1'b1;
        center_row_q <= row_eff - 1'b1;
      end
    end
  end

  assign window_out = window_q;
  assign win_valid  = win_valid_q;
  assign center_col = center_col_q;
  assign center_row = center_row_q;

endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed bench for window_3x3_gen on a 5x4 image, pixel value base+16*r+c.
module tb_window_3x3_gen;
  import window_3x3_gen_pkg::*;

  localparam int DW = 8;
  localparam int W  = 5;
  localparam int H  = 4;
  localparam int CW = clog2(W);
  localparam int RW = clog2(H);

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic            ce = 1'b0;
  logic            sof = 1'b0;
  logic [DW-1:0]   data_in = '0;
  logic [9*DW-1:0] window_out;
  logic            win_valid;
  logic [CW-1:0]   center_col;
  logic [RW-1:0]   center_row;

  window_3x3_gen #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .sof        (sof),
    .data_in    (data_in),
    .window_out (window_out),
    .win_valid  (win_valid),
    .center_col (center_col),
    .center_row (center_row)
  );

  // Scoreboard state
  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int dut_pulses = 0;
  logic [9*DW-1:0] exp_win = '0;
  logic [CW-1:0]   exp_col = '0;
  logic [RW-1:0]   exp_row = '0;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [9*DW-1:0] model_win(input int r, input int c, input int base);
    logic [9*DW-1:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(3*i+j)*DW +: DW] = DW'(base + 16*(r-2+i) + (c-2+j));
    return w;
  endfunction

  // Driver: apply inputs, take one edge, settle 1 time unit past it.
  task automatic drive(input logic c_e, input logic s, input logic [DW-1:0] d);
    ce = c_e; sof = s; data_in = d;
    @(posedge clk); #1;
    if (win_valid === 1'b1) dut_pulses++;
  endtask

  task automatic idle();
    drive(1'b0, 1'($urandom_range(0, 1)), DW'($urandom_range(0, 255)));
    chk("idle_valid", win_valid, 0);
    chk("idle_win_hold", window_out, exp_win);
    chk("idle_ccol_hold", center_col, exp_col);
    chk("idle_crow_hold", center_row, exp_row);
  endtask

  task automatic pix(input int r, input int c, input int base, input bit s, input bit gaps);
    int g;
    g = 0;
    if (gaps) begin
      while (g < 3 && $urandom_range(0, 99) < 40) begin
        idle();
        g++;
      end
    end
    drive(1'b1, s, DW'(base + 16*r + c));
    if (r >= 2 && c >= 2) begin
      exp_win = model_win(r, c, base);
      exp_col = CW'(c - 1);
      exp_row = RW'(r - 1);
      chk($sformatf("valid r%0d c%0d", r, c), win_valid, 1);
      chk($sformatf("window r%0d c%0d", r, c), window_out, exp_win);
    end else begin
      chk($sformatf("novalid r%0d c%0d", r, c), win_valid, 0);
    end
    chk($sformatf("ccol r%0d c%0d", r, c), center_col, exp_col);
    chk($sformatf("crow r%0d c%0d", r, c), center_row, exp_row);
  endtask

  // Stream linear pixel indices [from..to] of one frame.
  task automatic run(input int base, input int from, input int to, input bit gaps, input bit use_sof);
    for (int n = from; n <= to; n++)
      pix(n / W, n % W, base, use_sof && (n == 0), gaps);
  endtask

  task automatic reset_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DW'($urandom_range(0, 255)));
      chk("rst_win", window_out, 0);
      chk("rst_valid", win_valid, 0);
      chk("rst_ccol", center_col, 0);
      chk("rst_crow", center_row, 0);
    end
  endtask

  initial begin
    // Scenario 1: reset held with random activity
    rst = 1'b0;
    reset_cycles(8);
    chk("rst_no_pulse", 32'(dut_pulses), 0);
    rst = 1'b1;
    exp_win = '0; exp_col = '0; exp_row = '0;

    // Scenario 2 + 4: full frame, ce always high
    dut_pulses = 0;
    run(0, 0, 0, 0, 1);
    chk("win_zero_before_first", window_out, 0);
    run(0, 1, 12, 0, 1);
    chk("first_window", window_out, 72'h22_21_20_12_11_10_02_01_00);
    chk("first_ccol", center_col, 1);
    chk("first_crow", center_row, 1);
    run(0, 13, 17, 0, 1);
    chk("row_bdy_ccol", center_col, 1);
    chk("row_bdy_crow", center_row, 2);
    chk("row_bdy_tap0", window_out[TAP_TL*DW +: DW], 8'h10);
    run(0, 18, 19, 0, 1);
    chk("last_ccol", center_col, 3);
    chk("last_crow", center_row, 2);
    chk("last_tap8", window_out[TAP_BR*DW +: DW], 8'h34);
    chk("frame1_pulses", 32'(dut_pulses), 6);

    // Scenario 3: same frame with random ce gaps
    dut_pulses = 0;
    run(0, 0, 19, 1, 1);
    chk("gap_frame_pulses", 32'(dut_pulses), 6);
    chk("gap_last_tap4", window_out[TAP_MC*DW +: DW], 8'h23);

    // Scenario 5: sof reasserted at old pixel (2,3)
    run(0, 0, 12, 0, 1);
    dut_pulses = 0;
    run(8'h80, 0, 11, 0, 1);
    chk("restart_no_pulse", 32'(dut_pulses), 0);
    run(8'h80, 12, 12, 0, 1);
    chk("restart_window", window_out, 72'hA2_A1_A0_92_91_90_82_81_80);
    chk("restart_ccol", center_col, 1);
    chk("restart_crow", center_row, 1);
    run(8'h80, 13, 19, 0, 1);
    chk("restart_pulses", 32'(dut_pulses), 6);

    // Scenario 6: reset mid-frame at (2,1), restart without sof
    run(0, 0, 10, 0, 1);
    rst = 1'b0;
    #1;
    chk("async_rst_win", window_out, 0);
    chk("async_rst_valid", win_valid, 0);
    reset_cycles(3);
    rst = 1'b1;
    exp_win = '0; exp_col = '0; exp_row = '0;
    dut_pulses = 0;
    run(8'h40, 0, 11, 0, 0);
    chk("post_rst_no_pulse", 32'(dut_pulses), 0);
    run(8'h40, 12, 12, 0, 0);
    chk("post_rst_first_ccol", center_col, 1);
    chk("post_rst_first_crow", center_row, 1);
    chk("post_rst_first_tap4", window_out[TAP_MC*DW +: DW], 8'h51);
    run(8'h40, 13, 19, 0, 0);
    chk("post_rst_pulses", 32'(dut_pulses), 6);

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
